// File: rtl/gte_pkg.sv
// Shared definitions for the sequential GTE comparator: FSM states and digit width.
package gte_pkg;

  localparam int unsigned DIGIT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gt2_slice.sv
// Combinational 2-bit unsigned magnitude compare slice.
module gt2_slice
  import gte_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  output logic               gt,
  output logic               eq
);

  always_comb begin
    gt = (x > y);
    eq = (x == y);
  end

endmodule

// File: rtl/gte_seq_ctrl.sv
// Sequential MSB-first magnitude comparator sharing one 2-bit slice over W bits.
// Optional early termination on first differing digit: define GTE_EARLY_EXIT_EN.
module gte_seq_ctrl
  import gte_pkg::*;
#(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done,
  output logic         a_gt_b,
  output logic         a_eq_b,
  output logic         a_gte_b
);

  localparam int unsigned NDIG  = W / DIGIT_W;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  generate
    if ((W < 2) || ((W % 2) != 0)) begin : g_bad_width
      $error("gte_seq_ctrl: W must be even and >= 2");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [W-1:0]     sa, sb;
  logic [CNT_W-1:0] cnt;
  logic             decided, gt;

  logic slice_gt, slice_eq;
  logic decided_fin, gt_fin, last_digit, finish;

  gt2_slice u_slice (
    .x  (sa[W-1 -: DIGIT_W]),
    .y  (sb[W-1 -: DIGIT_W]),
    .gt (slice_gt),
    .eq (slice_eq)
  );

  // Sticky flags merged with the digit under compare this cycle.
  always_comb begin
    decided_fin = decided | ~slice_eq;
    gt_fin      = decided ? gt : slice_gt;
    last_digit  = (cnt == LAST);
`ifdef GTE_EARLY_EXIT_EN
    finish      = last_digit | ~slice_eq;
`else
    finish      = last_digit;
`endif
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start)  state_nxt = ST_RUN;
      ST_RUN:  if (finish) state_nxt = ST_DONE;
      ST_DONE:             state_nxt = ST_IDLE;
      default:             state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == ST_IDLE);
    done  = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      gt      <= 1'b0;
      a_gt_b  <= 1'b0;
      a_eq_b  <= 1'b0;
      a_gte_b <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa      <= a;
            sb      <= b;
            cnt     <= '0;
            decided <= 1'b0;
            gt      <= 1'b0;
          end
        end
        ST_RUN: begin
          sa      <= sa << DIGIT_W;
          sb      <= sb << DIGIT_W;
          cnt     <= cnt + CNT_W'(1);
          decided <= decided_fin;
          gt      <= gt_fin;
          if (finish) begin
            a_gt_b  <= gt_fin;
            a_eq_b  <= ~decided_fin;
            a_gte_b <= gt_fin | ~decided_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
